fetch: RTL and testbench



---
 rtl/fetch.sv | 33 +++
 tb/tb_fetch.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Program-counter register for the single-cycle CPU fetch stage.
// Each rising edge loads PC+4, or B_addr when a conditional branch is taken.
module fetch (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        B,
    input  logic        Z,
    input  logic [31:0] B_addr,
    output logic [31:0] addr
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        take;

    // Wraps modulo 2^32; there is no carry out.
    assign pc_plus4 = pc_reg + 32'd4;
    assign take     = B & Z;
    // The branch target is used verbatim: no offset, shift or alignment.
    assign pc_next  = take ? B_addr : pc_plus4;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_reg <= 32'h0000_0000;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign addr = pc_reg;

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: stimulus pushes expected PCs, a monitor pops and
// compares them one clock-to-q after each rising edge.
module tb_fetch;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        B = 1'b0;
    logic        Z = 1'b0;
    logic [31:0] B_addr = 32'h0;
    logic [31:0] addr;

    logic [31:0] exp_q[$];
    logic [31:0] pc_model;
    int          checks = 0;
    int          errors = 0;
    bit          stim_done = 1'b0;

    fetch dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .B      (B),
        .Z      (Z),
        .B_addr (B_addr),
        .addr   (addr)
    );

    always #5 Clock = ~Clock;

    // Monitor: the DUT presents a new PC after every rising edge.
    initial begin : monitor
        logic [31:0] exp_v;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (addr !== exp_v) begin
                    errors++;
                    $display("FAIL edge_pc t=%0t addr=%08h expected=%08h", $time, addr, exp_v);
                end else begin
                    $display("edge_pc t=%0t addr=%08h ok", $time, addr);
                end
            end
        end
    end

    // One transaction: drive inputs on the falling edge, predict the PC after
    // the following rising edge. Asserting reset is checked immediately.
    task automatic step(input logic rst, input logic b, input logic z, input logic [31:0] ba);
        @(negedge Clock);
        Reset  = rst;
        B      = b;
        Z      = z;
        B_addr = ba;
        if (!rst) begin
            pc_model = 32'h0;
            #1;
            checks++;
            if (addr !== 32'h0) begin
                errors++;
                $display("FAIL async_reset t=%0t addr=%08h expected=00000000", $time, addr);
            end else begin
                $display("async_reset t=%0t addr=00000000 ok", $time);
            end
        end else if (b && z) begin
            pc_model = ba;
        end else begin
            pc_model = pc_model + 32'd4;
        end
        exp_q.push_back(pc_model);
    endtask

    task automatic check_model(input string name, input logic [31:0] want);
        checks++;
        if (pc_model !== want) begin
            errors++;
            $display("FAIL %s model=%08h expected=%08h", name, pc_model, want);
        end
    endtask

    initial begin : stimulus
        int waited;
        pc_model = 32'h0;

        // Power-up: reset asserted between edges.
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (addr !== 32'h0) begin
            errors++;
            $display("FAIL powerup addr=%08h expected=00000000", addr);
        end else begin
            $display("powerup addr=00000000 ok");
        end

        step(1'b0, 1'b1, 1'b1, 32'h1234_5678);   // edge during reset ignored
        step(1'b1, 1'b0, 1'b0, 32'h0);            // -> 4
        check_model("seq1", 32'h4);
        step(1'b1, 1'b1, 1'b0, 32'h0F0F_0F0F);    // not taken -> 8
        check_model("not_taken", 32'h8);
        step(1'b1, 1'b0, 1'b1, 32'h0F0F_0F0F);    // Z alone -> C
        check_model("z_alone", 32'hC);
        step(1'b1, 1'b1, 1'b1, 32'h0F0F_0F0F);    // taken
        check_model("taken", 32'h0F0F_0F0F);
        step(1'b1, 1'b0, 1'b0, 32'h0);            // -> 0F0F0F13
        check_model("after_branch", 32'h0F0F_0F13);
        step(1'b1, 1'b1, 1'b1, 32'h0F0F_0F0F);
        step(1'b0, 1'b1, 1'b1, 32'h0F0F_0F0F);    // async clear, edge ignored
        step(1'b0, 1'b1, 1'b1, 32'h0F0F_0F0F);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0);            // wrap to 0
        check_model("wrap", 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0013);    // unaligned target kept
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_model("unaligned", 32'h17);

        for (int i = 0; i < 300; i++) begin
            logic        r;
            logic [31:0] ba;
            r  = ($urandom_range(0, 39) != 0);
            ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            step(r, 1'($urandom), 1'($urandom), ba);
        end

        stim_done = 1'b1;
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge Clock);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
